// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter stage.
package pc_pkg;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_PC_STEP      = 4;

    // Encoding order is the redirect priority; a larger value wins.
    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JALR = 2'd2,
        SRC_TRAP = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_target_adder.sv
// Modulo-2^XLEN target adder; optionally clears bit 0 of the sum (JALR rule).
module pc_target_adder #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_clr_bit0,
    output logic [XLEN-1:0] o_sum
);

    logic [XLEN-1:0] w_raw;

    assign w_raw = i_a + i_b;
    assign o_sum = {w_raw[XLEN-1:1], w_raw[0] & ~i_clr_bit0};

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, redirect selection, stall/pending handling.
// Optional macro RVC_EN adds is_compressed_i (2-byte step, bit-0 misalign check).
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     PC_STEP      = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic            jump_i,
    input  logic            jalr_i,
    input  logic            trap_i,
`ifdef RVC_EN
    input  logic            is_compressed_i,
`endif
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_link_o,
    output logic            fetch_valid_o,
    output logic            redirect_pending_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o,
    output logic [1:0]      state_o
);

    // Fetch handshake: pc_o is a fetch request whenever fetch_valid_o=1;
    // stall_i=1 means the consumer did not take it, so pc_o is held.
    pc_state_e       r_state;
    pc_state_e       w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_target;
    logic [XLEN-1:0] r_bad_addr;
    pc_src_e         r_pend_src;
    logic            r_pend_valid;
    logic            r_misalign;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_seq_target;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jalr_target;

    pc_src_e         w_fresh_src;
    logic [XLEN-1:0] w_fresh_raw;
    logic [XLEN-1:0] w_fresh_target;
    logic            w_fresh_valid;
    logic            w_fresh_mis;
    logic            w_pend_overwrite;
    logic            w_fresh_beats_pend;

    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pend_target_next;
    pc_src_e         w_pend_src_next;
    logic            w_pend_valid_next;
    logic            w_mis_next;

`ifdef RVC_EN
    assign w_step = is_compressed_i ? XLEN'(2) : XLEN'(PC_STEP);
`else
    assign w_step = XLEN'(PC_STEP);
`endif

    pc_target_adder #(.XLEN(XLEN)) u_seq_adder (
        .i_a        (r_pc),
        .i_b        (w_step),
        .i_clr_bit0 (1'b0),
        .o_sum      (w_seq_target)
    );

    pc_target_adder #(.XLEN(XLEN)) u_br_adder (
        .i_a        (ex_pc_i),
        .i_b        (imm_i),
        .i_clr_bit0 (1'b0),
        .o_sum      (w_br_target)
    );

    pc_target_adder #(.XLEN(XLEN)) u_jalr_adder (
        .i_a        (rs1_i),
        .i_b        (imm_i),
        .i_clr_bit0 (1'b1),
        .o_sum      (w_jalr_target)
    );

    always_comb begin
        w_fresh_src = SRC_SEQ;
        w_fresh_raw = w_seq_target;
        if (trap_i) begin
            w_fresh_src = SRC_TRAP;
            w_fresh_raw = TRAP_VECTOR;
        end else if (jalr_i) begin
            w_fresh_src = SRC_JALR;
            w_fresh_raw = w_jalr_target;
        end else if (jump_i || branch_taken_i) begin
            w_fresh_src = SRC_BR;
            w_fresh_raw = w_br_target;
        end
    end

    assign w_fresh_valid = (w_fresh_src != SRC_SEQ);

`ifdef RVC_EN
    assign w_fresh_mis = w_fresh_valid && (w_fresh_src != SRC_TRAP) && w_fresh_raw[0];
`else
    assign w_fresh_mis = w_fresh_valid && (w_fresh_src != SRC_TRAP) && w_fresh_raw[1];
`endif

    // A misaligned redirect is turned into a trap before it is loaded or latched.
    assign w_fresh_target     = w_fresh_mis ? TRAP_VECTOR : w_fresh_raw;
    assign w_pend_overwrite   = w_fresh_valid &&
                                (!r_pend_valid || (r_pend_src != SRC_TRAP) || (w_fresh_src == SRC_TRAP));
    assign w_fresh_beats_pend = w_fresh_valid && (w_fresh_src > r_pend_src);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     w_state_next = (stall_i && (w_fresh_valid || r_pend_valid)) ? PEND : RUN;
            PEND:    w_state_next = stall_i ? PEND : RUN;
            default: w_state_next = BOOT;
        endcase
    end

    always_comb begin
        w_pc_next          = r_pc;
        w_pend_valid_next  = r_pend_valid;
        w_pend_src_next    = r_pend_src;
        w_pend_target_next = r_pend_target;
        w_mis_next         = 1'b0;
        if ((r_state == BOOT) || stall_i) begin
            if (w_pend_overwrite) begin
                w_pend_valid_next  = 1'b1;
                w_pend_src_next    = w_fresh_mis ? SRC_TRAP : w_fresh_src;
                w_pend_target_next = w_fresh_target;
                w_mis_next         = w_fresh_mis;
            end
        end else if (r_pend_valid && !w_fresh_beats_pend) begin
            w_pc_next         = r_pend_target;
            w_pend_valid_next = 1'b0;
        end else begin
            w_pc_next         = w_fresh_target;
            w_pend_valid_next = 1'b0;
            w_mis_next        = w_fresh_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_VECTOR;
            r_pend_valid  <= 1'b0;
            r_pend_src    <= SRC_SEQ;
            r_pend_target <= '0;
            r_misalign    <= 1'b0;
            r_bad_addr    <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_src    <= w_pend_src_next;
            r_pend_target <= w_pend_target_next;
            r_misalign    <= w_mis_next;
            if (w_mis_next) begin
                r_bad_addr <= w_fresh_raw;
            end
        end
    end

    always_comb begin
        pc_o               = r_pc;
        pc_link_o          = w_seq_target;
        fetch_valid_o      = (r_state != BOOT);
        redirect_pending_o = r_pend_valid;
        misalign_o         = r_misalign;
        bad_addr_o         = r_bad_addr;
        state_o            = r_state;
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit; expected values are hand-computed constants.
module tb_pc_next_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] ST_BOOT = 32'd0;
    localparam logic [31:0] ST_RUN  = 32'd1;
    localparam logic [31:0] ST_PEND = 32'd2;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall_i;
    logic            branch_taken_i;
    logic            jump_i;
    logic            jalr_i;
    logic            trap_i;
    logic            is_compressed_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_link_o;
    logic            fetch_valid_o;
    logic            redirect_pending_o;
    logic            misalign_o;
    logic [XLEN-1:0] bad_addr_o;
    logic [1:0]      state_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    pc_next_unit #(.XLEN(XLEN)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .branch_taken_i     (branch_taken_i),
        .jump_i             (jump_i),
        .jalr_i             (jalr_i),
        .trap_i             (trap_i),
`ifdef RVC_EN
        .is_compressed_i    (is_compressed_i),
`endif
        .ex_pc_i            (ex_pc_i),
        .rs1_i              (rs1_i),
        .imm_i              (imm_i),
        .pc_o               (pc_o),
        .pc_link_o          (pc_link_o),
        .fetch_valid_o      (fetch_valid_o),
        .redirect_pending_o (redirect_pending_o),
        .misalign_o         (misalign_o),
        .bad_addr_o         (bad_addr_o),
        .state_o            (state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // checker
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        jump_i          = 1'b0;
        jalr_i          = 1'b0;
        trap_i          = 1'b0;
        is_compressed_i = 1'b0;
        ex_pc_i         = '0;
        rs1_i           = '0;
        imm_i           = '0;
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_fv", 32'(fetch_valid_o), 32'd0);
        check_eq("rst_pend", 32'(redirect_pending_o), 32'd0);
        check_eq("rst_mis", 32'(misalign_o), 32'd0);
        check_eq("rst_bad", bad_addr_o, 32'h0);
        check_eq("rst_state", 32'(state_o), ST_BOOT);

        rst = 1'b1;
        tick();
        check_eq("run_state", 32'(state_o), ST_RUN);
        check_eq("run_fv", 32'(fetch_valid_o), 32'd1);
        check_eq("link0", pc_link_o, 32'h4);

        // sequential fetch: 0, 4, 8, 12
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_pc", pc_o, exp_q.pop_front());
            if (i < 3) tick();
        end

        // branch: 0x40 + (-16) = 0x30
        branch_taken_i = 1'b1; ex_pc_i = 32'h40; imm_i = 32'hFFFF_FFF0;
        tick();
        clear_in();
        check_eq("branch_pc", pc_o, 32'h30);

        // JALR beats JAL; bit 0 of 0x105 cleared
        jalr_i = 1'b1; jump_i = 1'b1; rs1_i = 32'h101; imm_i = 32'h4; ex_pc_i = 32'h40;
        tick();
        clear_in();
        check_eq("jalr_pc", pc_o, 32'h104);

        // JAL during a 3-cycle stall
        stall_i = 1'b1; jump_i = 1'b1; ex_pc_i = 32'h80; imm_i = 32'h20;
        tick();
        jump_i = 1'b0;
        check_eq("stall_pc0", pc_o, 32'h104);
        check_eq("stall_pend0", 32'(redirect_pending_o), 32'd1);
        check_eq("stall_state", 32'(state_o), ST_PEND);
        tick();
        tick();
        check_eq("stall_pc2", pc_o, 32'h104);
        check_eq("stall_pend2", 32'(redirect_pending_o), 32'd1);
        clear_in();
        tick();
        check_eq("release_pc", pc_o, 32'hA0);
        check_eq("release_pend", 32'(redirect_pending_o), 32'd0);
        check_eq("release_state", 32'(state_o), ST_RUN);

        // branch target 0x1002
        branch_taken_i = 1'b1; ex_pc_i = 32'h1000; imm_i = 32'h2;
        tick();
        clear_in();
`ifdef RVC_EN
        check_eq("mis_pc", pc_o, 32'h1002);
        check_eq("mis_pulse", 32'(misalign_o), 32'd0);
        tick();
        check_eq("mis_after_pc", pc_o, 32'h1006);
`else
        check_eq("mis_pc", pc_o, 32'h100);
        check_eq("mis_pulse", 32'(misalign_o), 32'd1);
        check_eq("mis_bad", bad_addr_o, 32'h1002);
        tick();
        check_eq("mis_after_pc", pc_o, 32'h104);
        check_eq("mis_bad_hold", bad_addr_o, 32'h1002);
`endif
        check_eq("mis_once", 32'(misalign_o), 32'd0);

        // wrap at top of address space
        jalr_i = 1'b1; rs1_i = 32'hFFFF_FFFC; imm_i = 32'h0;
        tick();
        clear_in();
        check_eq("wrap_top", pc_o, 32'hFFFF_FFFC);
        check_eq("wrap_link", pc_link_o, 32'h0);
        tick();
        check_eq("wrap_pc", pc_o, 32'h0);

        // trap with a misaligned JALR: trap wins, no misalign
        trap_i = 1'b1; jalr_i = 1'b1; rs1_i = 32'h201; imm_i = 32'h1;
        tick();
        clear_in();
        check_eq("trap_pc", pc_o, 32'h100);
        check_eq("trap_mis", 32'(misalign_o), 32'd0);
        tick();
        check_eq("trap_seq", pc_o, 32'h104);

        // pending trap is not replaced by a later JALR
        stall_i = 1'b1; trap_i = 1'b1;
        tick();
        trap_i = 1'b0; jalr_i = 1'b1; rs1_i = 32'h300;
        tick();
        check_eq("ptrap_hold", pc_o, 32'h104);
        clear_in();
        tick();
        check_eq("ptrap_pc", pc_o, 32'h100);

        // pending branch loses to a fresh JALR at release
        stall_i = 1'b1; branch_taken_i = 1'b1; ex_pc_i = 32'h0; imm_i = 32'h200;
        tick();
        clear_in();
        jalr_i = 1'b1; rs1_i = 32'h400;
        tick();
        clear_in();
        check_eq("rel_hi_pc", pc_o, 32'h400);

        // pending JALR beats a fresh branch at release
        stall_i = 1'b1; jalr_i = 1'b1; rs1_i = 32'h500;
        tick();
        clear_in();
        branch_taken_i = 1'b1; ex_pc_i = 32'h0; imm_i = 32'h600;
        tick();
        clear_in();
        check_eq("rel_lo_pc", pc_o, 32'h500);

        // reset discards a pending redirect
        stall_i = 1'b1; jump_i = 1'b1; ex_pc_i = 32'h0; imm_i = 32'h700;
        tick();
        clear_in();
        check_eq("pre_rst_pend", 32'(redirect_pending_o), 32'd1);
        rst = 1'b0;
        tick();
        check_eq("mid_rst_pc", pc_o, 32'h0);
        check_eq("mid_rst_pend", 32'(redirect_pending_o), 32'd0);
        check_eq("mid_rst_state", 32'(state_o), ST_BOOT);
        rst = 1'b1;
        tick();
        check_eq("post_rst_pc", pc_o, 32'h0);
        tick();
        check_eq("post_rst_seq", pc_o, 32'h4);

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised program-counter stage for the RISC-V core. Replaces the bare PC+constant adder.
- Holds the PC register and computes sequential and redirect targets: branch/JAL, JALR and trap.
- Supports stall, remembers a redirect that arrives during a stall, and flags misaligned targets.
- Sits between the execute-stage redirect logic and the instruction-memory address port.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- stall_i  in  1  hold PC (pipeline back-pressure).
- branch_taken_i  in  1  conditional branch resolved taken; target = ex_pc_i + imm_i.
- jump_i  in  1  JAL; target = ex_pc_i + imm_i.
- jalr_i  in  1  JALR; target = (rs1_i + imm_i) with bit 0 cleared.
- trap_i  in  1  exception/interrupt; target = TRAP_VECTOR.
- ex_pc_i  in  XLEN  PC of the redirecting instruction.
- rs1_i  in  XLEN  JALR base register.
- imm_i  in  XLEN  sign-extended immediate.
- pc_o  out  XLEN  current fetch address.
- pc_link_o  out  XLEN  pc_o + PC_STEP, combinational (rd value for JAL/JALR).
- fetch_valid_o  out  1  pc_o is a valid fetch this cycle.
- redirect_pending_o  out  1  redirect latched while stalled.
- misalign_o  out  1  one-cycle pulse: misaligned redirect target.
- bad_addr_o  out  XLEN  offending target, captured on misalign.

Behaviour:
- Reset (rst=0 at clk edge) values:
  - pc_o=RESET_VECTOR
  - fetch_valid_o=0
  - redirect_pending_o=0
  - misalign_o=0
  - bad_addr_o=0
  - state=BOOT
  - Reset mid-operation discards any pending redirect.
- All additions are modulo 2^XLEN; carry is discarded. 0xFFFF_FFFC + 4 wraps to 0.
- Redirect priority: trap_i > jalr_i > jump_i > branch_taken_i > sequential.
- Misalign check (RVC_EN off): a selected non-trap target with bit[1]=1 is misaligned.
  - It is not loaded. Next PC = TRAP_VECTOR.
  - misalign_o=1 for exactly one cycle; bad_addr_o = that target.
- States:
  - BOOT:
    - Exactly one cycle after reset release. fetch_valid_o=0, pc_o held.
    - Next state RUN, regardless of stall_i.
    - Redirects arriving during BOOT are latched into the pending register.
  - RUN:
    - fetch_valid_o=1.
    - No stall: pc_o <= selected target (latency 1 cycle from redirect input to pc_o).
    - Stall with no redirect: pc_o held.
    - Stall with a redirect: target latched into the pending register; pc_o held; next state PEND.
  - PEND:
    - redirect_pending_o=1; fetch_valid_o=1; pc_o held.
    - A newer redirect overwrites the pending one, except that a pending trap is only overwritten by another trap.
    - When stall_i=0: pc_o <= pending target, state RUN, redirect_pending_o=0 on the same edge.
    - A fresh redirect on that same release cycle beats the pending one only if it has higher priority.
- Simultaneous trap_i and misaligned jalr: trap wins and misalign_o stays 0.

Optional Feature:
- Macro: RVC_EN.
- Defined:
  - Adds input is_compressed_i (1 bit).
  - Sequential step and pc_link_o increment = 2 when is_compressed_i=1, otherwise PC_STEP.
  - Misalign check only on bit[0], which JALR clears; branch/JAL targets with bit[0]=1 still flag.
- Undefined:
  - Port absent; step is always PC_STEP; check on bit[1] as above.

Decomposition:
- pc_pkg:
  - typedef pc_src_e (SRC_SEQ, SRC_BR, SRC_JALR, SRC_TRAP).
  - typedef pc_state_e (BOOT, RUN, PEND).
  - Default vector constants.
- Sub-module pc_target_adder: parametrised XLEN adder with optional bit-0 clear. Instanced three times: sequential, branch/JAL, JALR.

Test Plan:
- Reset and sequencing: rst low 2 cycles, then release -> pc_o=0, fetch_valid_o=0 for one cycle, then pc_o=0,4,8,12 on successive cycles.
- Branch redirect: branch_taken_i=1, ex_pc_i=0x40, imm_i=0xFFFF_FFF0 -> next pc_o=0x30.
- JALR: rs1_i=0x101, imm_i=0x4 -> pc_o=0x104 (bit 0 cleared). jump_i asserted in the same cycle is ignored.
- Stall with redirect: stall_i=1, jump_i=1, ex_pc_i=0x80, imm_i=0x20, stall held 3 cycles -> pc_o held, redirect_pending_o=1; after stall drops, pc_o=0xA0 next cycle.
- Misalign: branch target 0x1002 (RVC_EN off) -> misalign_o single pulse, bad_addr_o=0x1002, pc_o=0x100. Repeat with RVC_EN defined -> pc_o=0x1002, misalign_o=0.
- Wrap and trap priority: pc_o=0xFFFF_FFFC -> next pc_o=0. Then trap_i with jalr_i together -> pc_o=0x100.
